// File: rtl/car_motion_ctrl.sv
// Car slot register file plus frame-synchronous horizontal motion engine feeding the sprite renderer.
// Optional read-back mux enabled by defining CAR_MOTION_READBACK_EN; otherwise rd_data is tied to 0.
module car_motion_ctrl #(
    parameter int             N_CARS = 20,
    parameter int             CW     = 11,
    parameter int             H_MAX  = 640,
    parameter logic [CW-1:0]  Y_PARK = 11'h7FF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cs,
    input  logic                 write,
    input  logic [6:0]           addr,
    input  logic [31:0]          wr_data,
    output logic [31:0]          rd_data,
    input  logic                 frame_tick,
    output logic [N_CARS*CW-1:0] car_x,
    output logic [N_CARS*CW-1:0] car_y,
    output logic [N_CARS*4-1:0]  car_ctrl,
    output logic                 busy,
    output logic                 update_done
);

    typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_DONE} state_e;

    localparam logic [4:0] LAST_IDX = 5'(N_CARS - 1);
    localparam logic [6:0] GCTL     = 7'h7F;

    state_e       state_q, state_d;
    logic [4:0]   idx_q, idx_d;
    logic         busy_q, done_q, run_q, ovr_q;
    logic [CW-1:0] x_q    [N_CARS];
    logic [CW-1:0] y_q    [N_CARS];
    logic [3:0]    ctrl_q [N_CARS];
    logic [4:0]    spd_q  [N_CARS];   // {dir, speed}

    logic [1:0]    fld;
    logic [4:0]    slot;
    logic          we, gctl_sel, slot_ok, eng_en;
    logic [CW-1:0] eng_x;

    assign fld      = addr[6:5];
    assign slot     = addr[4:0];
    assign we       = cs && write;
    assign gctl_sel = (addr == GCTL);
    assign slot_ok  = !gctl_sel && (slot < 5'(N_CARS));
    assign eng_en   = (state_q == S_UPDATE);

    // One wrap-around step; a single correction is enough because speed < H_MAX.
    function automatic logic [CW-1:0] step(input logic [CW-1:0] x, input logic [4:0] sp);
        logic [11:0] xx, v, s;
        xx = 12'(x);
        v  = {8'b0, sp[3:0]};
        if (sp[3:0] == 4'd0) begin
            s = xx;
        end else if (!sp[4]) begin
            s = xx + v;
            if (s >= 12'(H_MAX)) s = s - 12'(H_MAX);
        end else begin
            s = (xx < v) ? (xx + 12'(H_MAX) - v) : (xx - v);
        end
        return s[CW-1:0];
    endfunction

    assign eng_x = step(x_q[idx_q], spd_q[idx_q]);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: if (frame_tick && run_q) begin
                state_d = S_UPDATE;
                idx_d   = 5'd0;
            end
            S_UPDATE: if (idx_q == LAST_IDX) state_d = S_DONE;
                      else                   idx_d   = idx_q + 5'd1;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= (state_d != S_IDLE);
            done_q  <= (state_d == S_DONE);
            if (we && gctl_sel) begin
                run_q <= wr_data[0];
                if (wr_data[1]) ovr_q <= 1'b0;
            end
            // A late tick is a lost frame; it outranks a same-cycle clear.
            if (frame_tick && run_q && state_q != S_IDLE) ovr_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_CARS; i++) begin
                x_q[i]    <= '0;
                y_q[i]    <= Y_PARK;
                ctrl_q[i] <= 4'd0;
                spd_q[i]  <= 5'd0;
            end
        end else begin
            for (int i = 0; i < N_CARS; i++) begin
                if (eng_en && idx_q == 5'(i)) x_q[i] <= eng_x;
                // Bus write comes last so it overrides the engine on the same slot.
                if (we && slot_ok && slot == 5'(i)) begin
                    case (fld)
                        2'b00:   x_q[i]    <= wr_data[CW-1:0];
                        2'b01:   y_q[i]    <= wr_data[CW-1:0];
                        2'b10:   ctrl_q[i] <= wr_data[3:0];
                        default: spd_q[i]  <= wr_data[4:0];
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < N_CARS; g++) begin : g_out
        assign car_x[g*CW +: CW]  = x_q[g];
        assign car_y[g*CW +: CW]  = y_q[g];
        assign car_ctrl[g*4 +: 4] = ctrl_q[g];
    end

    assign busy        = busy_q;
    assign update_done = done_q;

`ifdef CAR_MOTION_READBACK_EN
    always_comb begin
        rd_data = 32'h0;
        if (gctl_sel) begin
            rd_data = {29'b0, ovr_q, busy_q, run_q};
        end else if (slot_ok) begin
            case (fld)
                2'b00:   rd_data[CW-1:0] = x_q[slot];
                2'b01:   rd_data[CW-1:0] = y_q[slot];
                2'b10:   rd_data[3:0]    = ctrl_q[slot];
                default: rd_data[4:0]    = spd_q[slot];
            endcase
        end
    end
`else
    assign rd_data = 32'h0;
`endif

    logic unused_wd;
    assign unused_wd = ^wr_data[31:CW];

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Self-checking bench for car_motion_ctrl: directed boundary steps plus randomized frames vs a slot-level model.
module tb_car_motion_ctrl;
    localparam int N  = 20;
    localparam int CW = 11;
    localparam int HM = 640;

    logic              clk, reset_n, cs, write, frame_tick;
    logic [6:0]        addr;
    logic [31:0]       wr_data, rd_data;
    logic [N*CW-1:0]   car_x, car_y;
    logic [N*4-1:0]    car_ctrl;
    logic              busy, update_done;

    car_motion_ctrl dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .write(write), .addr(addr),
        .wr_data(wr_data), .rd_data(rd_data), .frame_tick(frame_tick),
        .car_x(car_x), .car_y(car_y), .car_ctrl(car_ctrl),
        .busy(busy), .update_done(update_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    // Model: plain per-car integers
    int mx[N], my[N], mc[N], msp[N], mdir[N];
    bit mrun, movr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int mstep(input int x, input int sp, input int dir);
        if (sp == 0) return x;
        return dir ? (x + HM - sp) % HM : (x + sp) % HM;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            mx[i] = 0; my[i] = 2047; mc[i] = 0; msp[i] = 0; mdir[i] = 0;
        end
        mrun = 0; movr = 0;
    endfunction

    function automatic void mwr(input logic [6:0] a, input logic [31:0] d);
        int s;
        s = int'(a[4:0]);
        if (a == 7'h7F) begin
            mrun = d[0];
            if (d[1]) movr = 0;
        end else if (s < N) begin
            case (a[6:5])
                2'b00: mx[s] = int'(d[10:0]);
                2'b01: my[s] = int'(d[10:0]);
                2'b10: mc[s] = int'(d[3:0]);
                2'b11: begin msp[s] = int'(d[3:0]); mdir[s] = int'(d[4]); end
            endcase
        end
    endfunction

    task automatic wr(input logic [6:0] a, input logic [31:0] d);
        cs = 1; write = 1; addr = a; wr_data = d;
        @(negedge clk);
        cs = 0; write = 0;
        mwr(a, d);
    endtask

    task automatic rdchk(input string tag, input logic [6:0] a, input logic [31:0] exp);
        addr = a;
        #1;
`ifdef CAR_MOTION_READBACK_EN
        chk(tag, rd_data, exp);
`else
        chk(tag, rd_data, 32'h0);
`endif
    endtask

    task automatic chk_slots(input string tag);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s x[%0d]", tag, i), 32'(car_x[i*CW +: CW]), 32'(mx[i]));
            chk($sformatf("%s y[%0d]", tag, i), 32'(car_y[i*CW +: CW]), 32'(my[i]));
            chk($sformatf("%s c[%0d]", tag, i), 32'(car_ctrl[i*4 +: 4]), 32'(mc[i]));
        end
    endtask

    // wslot<0 means the mid-frame write goes to the control register (run=0).
    task automatic run_frame(input int wslot, input int wcyc, input int wval, input int tcyc);
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        chk("busy E0", 32'(busy), 1);
        chk("done E0", 32'(update_done), 0);
        for (int c = 1; c <= N + 1; c++) begin
            if (c == wcyc) begin
                cs = 1; write = 1;
                addr = (wslot < 0) ? 7'h7F : {2'b00, 5'(wslot)};
                wr_data = (wslot < 0) ? 32'h0 : 32'(wval);
            end
            if (c == tcyc) frame_tick = 1;
            @(negedge clk);
            cs = 0; write = 0; frame_tick = 0;
            if (c <= N) mx[c-1] = mstep(mx[c-1], msp[c-1], mdir[c-1]);
            if (c == wcyc) begin
                if (wslot < 0) mrun = 0;
                else           mx[wslot] = wval;
            end
            if (c == tcyc && mrun) movr = 1;
            chk($sformatf("busy c%0d", c), 32'(busy), 32'(c <= N));
            chk($sformatf("done c%0d", c), 32'(update_done), 32'(c == N));
            if (tcyc != 0 && c == tcyc)
                rdchk("ctl in busy", 7'h7F, {29'b0, movr, c <= N, mrun});
        end
        chk_slots("frame");
    endtask

    task automatic chk_idle(input string tag);
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        for (int k = 0; k < 3; k++) begin
            chk(tag, 32'(busy), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        reset_n = 0; cs = 0; write = 0; addr = 0; wr_data = 0; frame_tick = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst done", 32'(update_done), 0);
        chk_slots("rst");
        rdchk("rst ctl", 7'h7F, 32'h0);
        reset_n = 1;
        @(negedge clk);

        // run=0: tick ignored, no overrun
        chk_idle("tick run0");
        rdchk("ctl run0", 7'h7F, 32'h0);

        // Directed motion and wrap cases
        wr({2'b00, 5'd3}, 100); wr({2'b11, 5'd3}, 5);
        wr({2'b00, 5'd4}, 638); wr({2'b11, 5'd4}, 5);
        wr({2'b00, 5'd5}, 2);   wr({2'b11, 5'd5}, 32'h15);
        wr({2'b00, 5'd6}, 5);   wr({2'b11, 5'd6}, 32'h15);
        wr(7'h7F, 1);
        run_frame(0, 0, 0, 0);
        chk("x3 right", 32'(car_x[3*CW +: CW]), 105);
        chk("x4 wrapR", 32'(car_x[4*CW +: CW]), 3);
        chk("x5 wrapL", 32'(car_x[5*CW +: CW]), 637);
        chk("x6 zeroL", 32'(car_x[6*CW +: CW]), 0);

        // Bus write to slot 0 x on its own update edge wins
        wr({2'b11, 5'd0}, 7);
        run_frame(0, 1, 50, 0);
        chk("x0 conflict", 32'(car_x[0 +: CW]), 50);

        // Overrun: tick during busy, then clear keeps run
        run_frame(0, 0, 0, 5);
        rdchk("ctl ovr", 7'h7F, 32'h5);
        wr(7'h7F, 3);
        rdchk("ctl clr", 7'h7F, 32'h1);

        // Out-of-range slot: write ignored, read 0
        wr({2'b00, 5'd25}, 123);
        rdchk("rd slot25", {2'b00, 5'd25}, 32'h0);

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            int ws, wc, tc;
            for (int i = 0; i < N; i++) begin
                wr({2'b00, 5'(i)}, $urandom_range(0, HM - 1));
                wr({2'b01, 5'(i)}, $urandom_range(0, 2047));
                wr({2'b10, 5'(i)}, $urandom_range(0, 15));
                wr({2'b11, 5'(i)}, $urandom_range(0, 31));
            end
            for (int k = 0; k < 3; k++) begin
                int s;
                s = $urandom_range(0, N - 1);
                rdchk("rd x", {2'b00, 5'(s)}, 32'(mx[s]));
                rdchk("rd y", {2'b01, 5'(s)}, 32'(my[s]));
                rdchk("rd c", {2'b10, 5'(s)}, 32'(mc[s]));
                rdchk("rd s", {2'b11, 5'(s)}, 32'({mdir[s][0], msp[s][3:0]}));
            end
            ws = $urandom_range(0, N - 1);
            wc = $urandom_range(1, N + 1);
            tc = ($urandom_range(0, 1) != 0) ? $urandom_range(1, N + 1) : 0;
            run_frame(ws, wc, $urandom_range(0, HM - 1), tc);
            wr(7'h7F, 3);
        end

        // run cleared mid-update: frame still completes, next tick ignored
        run_frame(-1, 8, 0, 0);
        chk_idle("tick after run clr");
        wr(7'h7F, 1);

        // Reset mid-update
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        repeat (10) @(negedge clk);
        #2 reset_n = 0;
        model_reset();
        #1;
        chk("midrst busy", 32'(busy), 0);
        chk("midrst done", 32'(update_done), 0);
        chk_slots("midrst");
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        chk_idle("tick after rst");

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
